// File: rtl/video_timing.sv
// video_timing: 640x480@60 VGA raster generator with 256x240 game-pixel coordinates.
// Game area is 512x480 VGA pixels (2x2 per game pixel), centred with a 64-pixel border.
// Optional feature macro: VIDEO_TIMING_IRQ_EN adds a sticky vblank interrupt (irq_o/irq_ack_i).
// All outputs are registered from next-state counter values, so they line up with the counters.
module video_timing #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned H_BORDER  = 64
) (
    input  logic       gpu_clk,
    input  logic       rst,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       visible_o,
    output logic [7:0] current_x_o,
    output logic [7:0] current_y_o,
    output logic       vblank_o,
    output logic       vblank_start_o
`ifdef VIDEO_TIMING_IRQ_EN
    ,
    input  logic       irq_ack_i,
    output logic       irq_o
`endif
);

    localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_GAME_START = 10'(H_BORDER);
    localparam logic [9:0] H_GAME_END   = 10'(H_BORDER + 512);
    localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;

    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_game_col;
    logic       w_v_vis;
    logic       w_hsync;
    logic       w_vsync;
    logic       w_visible;
    logic [7:0] w_x;
    logic [7:0] w_y;
    logic       w_vblank;
    logic       w_vblank_start;

    // Next counter position and the output decode of that position.
    always_comb begin
        w_h_next = r_hcount + 10'd1;
        w_v_next = r_vcount;
        if (r_hcount == H_LAST) begin
            w_h_next = 10'd0;
            w_v_next = (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
        end
        w_game_col     = (w_h_next >= H_GAME_START) && (w_h_next < H_GAME_END);
        w_v_vis        = (w_v_next < V_VIS);
        w_hsync        = !((w_h_next >= H_SYNC_START) && (w_h_next < H_SYNC_END));
        w_vsync        = !((w_v_next >= V_SYNC_START) && (w_v_next < V_SYNC_END));
        w_visible      = w_game_col && w_v_vis;
        w_x            = w_game_col ? 8'((w_h_next - H_GAME_START) >> 1) : 8'd0;
        w_y            = w_v_vis ? 8'(w_v_next >> 1) : 8'd0;
        w_vblank       = !w_v_vis;
        w_vblank_start = (w_h_next == 10'd0) && (w_v_next == V_VIS);
    end

    // Counter and output registers; reset parks the raster at pixel (0,0).
    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            r_hcount       <= 10'd0;
            r_vcount       <= 10'd0;
            hsync_o        <= 1'b1;
            vsync_o        <= 1'b1;
            visible_o      <= 1'b0;
            current_x_o    <= 8'd0;
            current_y_o    <= 8'd0;
            vblank_o       <= 1'b0;
            vblank_start_o <= 1'b0;
        end else begin
            r_hcount       <= w_h_next;
            r_vcount       <= w_v_next;
            hsync_o        <= w_hsync;
            vsync_o        <= w_vsync;
            visible_o      <= w_visible;
            current_x_o    <= w_x;
            current_y_o    <= w_y;
            vblank_o       <= w_vblank;
            vblank_start_o <= w_vblank_start;
        end
    end

`ifdef VIDEO_TIMING_IRQ_EN
    // Sticky vblank interrupt: set the cycle after the strobe; a coincident ack loses.
    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            irq_o <= 1'b0;
        end else if (vblank_start_o) begin
            irq_o <= 1'b1;
        end else if (irq_ack_i) begin
            irq_o <= 1'b0;
        end
    end
`endif

endmodule
